// File: rtl/tmds_channel_sequencer_pkg.sv
// rtl/tmds_channel_sequencer_pkg.sv - shared state encoding and control constants for the TMDS sequencer
package tmds_channel_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SYNC_ONLY  = 2'd1,
    ACTIVE     = 2'd2,
    MUTED      = 2'd3
  } seq_state_e;

  localparam logic [1:0] CTRL_IDLE = 2'b00;

endpackage

// File: rtl/tmds_channel_sequencer.sv
// rtl/tmds_channel_sequencer.sv - drives the three TMDS encoder inputs with startup sync-only frames and frame-aligned mute
module tmds_channel_sequencer
  import tmds_channel_sequencer_pkg::*;
#(
  parameter int STARTUP_FRAMES = 2,
  parameter int CNT_W          = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_frame,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  input  logic       i_mute_req,
  output logic       o_de,
  output logic [1:0] o_ctrl_ch0,
  output logic [1:0] o_ctrl_ch1,
  output logic [1:0] o_ctrl_ch2,
  output logic [7:0] o_data_ch0,
  output logic [7:0] o_data_ch1,
  output logic [7:0] o_data_ch2,
  output logic       o_video_on,
  output logic       o_muted
);

  // Index of the final sync-only frame; unused when no startup frames are configured.
  localparam logic [CNT_W-1:0] LAST_CNT =
    (STARTUP_FRAMES == 0) ? '0 : CNT_W'(STARTUP_FRAMES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       de_d;
  logic [1:0] ctrl0_d;
  logic [7:0] data0_d, data1_d, data2_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_FRAME: begin
        if (i_frame) begin
          cnt_d   = '0;
          state_d = (STARTUP_FRAMES == 0) ? ACTIVE : SYNC_ONLY;
        end
      end
      SYNC_ONLY: begin
        if (i_frame) begin
          if (cnt_q == LAST_CNT) state_d = i_mute_req ? MUTED : ACTIVE;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ACTIVE:  if (i_frame && i_mute_req)  state_d = MUTED;
      MUTED:   if (i_frame && !i_mute_req) state_d = ACTIVE;
      default: state_d = WAIT_FRAME;
    endcase
    if (!i_en) begin
      state_d = WAIT_FRAME;
      cnt_d   = '0;
    end
  end

  // Output treatment follows the next state so the frame-start pixel already reflects it.
  always_comb begin
    de_d    = 1'b0;
    ctrl0_d = CTRL_IDLE;
    data0_d = 8'h00;
    data1_d = 8'h00;
    data2_d = 8'h00;
    case (state_d)
      SYNC_ONLY: ctrl0_d = {i_vsync, i_hsync};
      ACTIVE: begin
        de_d    = i_de;
        ctrl0_d = {i_vsync, i_hsync};
        if (i_de) begin
          data0_d = i_b;
          data1_d = i_g;
          data2_d = i_r;
        end
      end
      MUTED: begin
        de_d    = i_de;
        ctrl0_d = {i_vsync, i_hsync};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= WAIT_FRAME;
      cnt_q      <= '0;
      o_de       <= 1'b0;
      o_ctrl_ch0 <= CTRL_IDLE;
      o_data_ch0 <= 8'h00;
      o_data_ch1 <= 8'h00;
      o_data_ch2 <= 8'h00;
      o_video_on <= 1'b0;
      o_muted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_de       <= de_d;
      o_ctrl_ch0 <= ctrl0_d;
      o_data_ch0 <= data0_d;
      o_data_ch1 <= data1_d;
      o_data_ch2 <= data2_d;
      o_video_on <= (state_d == ACTIVE) || (state_d == MUTED);
      o_muted    <= (state_d == MUTED);
    end
  end

  assign o_ctrl_ch1 = CTRL_IDLE;
  assign o_ctrl_ch2 = CTRL_IDLE;

endmodule

// File: tb/tb_tmds_channel_sequencer.sv
// tb/tb_tmds_channel_sequencer.sv - randomized self-checking bench for tmds_channel_sequencer
module tb_tmds_channel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, en, frame, hs, vs, de, mute;
  logic [7:0] r, g, b;
  bit         fix_r;

  logic       o_de_w  [2];
  logic [1:0] o_c0_w  [2];
  logic [1:0] o_c1_w  [2];
  logic [1:0] o_c2_w  [2];
  logic [7:0] o_d0_w  [2];
  logic [7:0] o_d1_w  [2];
  logic [7:0] o_d2_w  [2];
  logic       o_von_w [2];
  logic       o_mut_w [2];

  // Reference state: frame pulses seen since enable, and the mute level latched at the last pulse.
  int         n_frames [2];
  bit         mute_lat [2];
  logic       e_de  [2];
  logic [1:0] e_c0  [2];
  logic [7:0] e_d0  [2];
  logic [7:0] e_d1  [2];
  logic [7:0] e_d2  [2];
  logic       e_von [2];
  logic       e_mut [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmds_channel_sequencer #(.STARTUP_FRAMES(2), .CNT_W(4)) u_s2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_frame(frame),
    .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_r(r), .i_g(g), .i_b(b),
    .i_mute_req(mute), .o_de(o_de_w[0]), .o_ctrl_ch0(o_c0_w[0]),
    .o_ctrl_ch1(o_c1_w[0]), .o_ctrl_ch2(o_c2_w[0]), .o_data_ch0(o_d0_w[0]),
    .o_data_ch1(o_d1_w[0]), .o_data_ch2(o_d2_w[0]), .o_video_on(o_von_w[0]),
    .o_muted(o_mut_w[0])
  );

  tmds_channel_sequencer #(.STARTUP_FRAMES(0), .CNT_W(4)) u_s0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_frame(frame),
    .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_r(r), .i_g(g), .i_b(b),
    .i_mute_req(mute), .o_de(o_de_w[1]), .o_ctrl_ch0(o_c0_w[1]),
    .o_ctrl_ch1(o_c1_w[1]), .o_ctrl_ch2(o_c2_w[1]), .o_data_ch0(o_d0_w[1]),
    .o_data_ch1(o_d1_w[1]), .o_data_ch2(o_d2_w[1]), .o_video_on(o_von_w[1]),
    .o_muted(o_mut_w[1])
  );

  task automatic chk(input string tag, input int j, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0t: observed=%h expected=%h", tag, j, $time, obs, exp);
    end
  endtask

  task automatic model();
    for (int j = 0; j < 2; j++) begin
      int startup;
      bit sync, video;
      startup = (j == 0) ? 2 : 0;
      if (!en) begin
        n_frames[j] = 0;
      end else if (frame) begin
        // The first pulse after enable never samples mute; later pulses do.
        mute_lat[j] = (n_frames[j] == 0) ? 1'b0 : mute;
        if (n_frames[j] <= startup) n_frames[j]++;
      end
      sync     = n_frames[j] > 0;
      video    = n_frames[j] > startup;
      e_de[j]  = video & de;
      e_c0[j]  = sync ? {vs, hs} : 2'b00;
      e_d0[j]  = (video && !mute_lat[j] && de) ? b : 8'h00;
      e_d1[j]  = (video && !mute_lat[j] && de) ? g : 8'h00;
      e_d2[j]  = (video && !mute_lat[j] && de) ? r : 8'h00;
      e_von[j] = video;
      e_mut[j] = video & mute_lat[j];
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < 2; j++) begin
      chk("de",       j, 8'(o_de_w[j]),  8'(e_de[j]));
      chk("ctrl_ch0", j, 8'(o_c0_w[j]),  8'(e_c0[j]));
      chk("ctrl_ch1", j, 8'(o_c1_w[j]),  8'h00);
      chk("ctrl_ch2", j, 8'(o_c2_w[j]),  8'h00);
      chk("data_ch0", j, o_d0_w[j],      e_d0[j]);
      chk("data_ch1", j, o_d1_w[j],      e_d1[j]);
      chk("data_ch2", j, o_d2_w[j],      e_d2[j]);
      chk("video_on", j, 8'(o_von_w[j]), 8'(e_von[j]));
      chk("muted",    j, 8'(o_mut_w[j]), 8'(e_mut[j]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk({tag, "_de"},    j, 8'(o_de_w[j]),  8'h00);
      chk({tag, "_ctrl0"}, j, 8'(o_c0_w[j]),  8'h00);
      chk({tag, "_data0"}, j, o_d0_w[j],      8'h00);
      chk({tag, "_data1"}, j, o_d1_w[j],      8'h00);
      chk({tag, "_data2"}, j, o_d2_w[j],      8'h00);
      chk({tag, "_von"},   j, 8'(o_von_w[j]), 8'h00);
      chk({tag, "_muted"}, j, 8'(o_mut_w[j]), 8'h00);
    end
  endtask

  task automatic cycle(input bit fr);
    frame = fr;
    hs    = 1'($urandom);
    vs    = 1'($urandom);
    de    = 1'($urandom);
    r     = fix_r ? 8'hAA : 8'($urandom);
    g     = 8'($urandom);
    b     = 8'($urandom);
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_frame(input int len);
    cycle(1'b1);
    repeat (len - 1) cycle(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; frame = 1'b0; mute = 1'b0;
    hs = 1'b0; vs = 1'b0; de = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
    fix_r = 1'b1;
    for (int j = 0; j < 2; j++) begin
      n_frames[j] = 0;
      mute_lat[j] = 1'b0;
    end
    #23;
    check_zero("reset");
    #1;
    rst_n = 1'b1;
    en    = 1'b1;

    // Startup: partial frame discarded, then sync-only frames before video.
    repeat (30) cycle(1'b0);
    repeat (4) run_frame(100);
    fix_r = 1'b0;

    // Mute raised and dropped mid-frame only takes effect at the next pulse.
    cycle(1'b1);
    repeat (40) cycle(1'b0);
    mute = 1'b1;
    repeat (59) cycle(1'b0);
    cycle(1'b1);
    repeat (30) cycle(1'b0);
    mute = 1'b0;
    repeat (69) cycle(1'b0);
    run_frame(100);

    // Enable dropped mid-frame, a pulse while disabled, then restart.
    repeat (20) cycle(1'b0);
    en = 1'b0;
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    en = 1'b1;
    repeat (10) cycle(1'b0);
    repeat (3) run_frame(100);
    run_frame(50);

    // Enable and frame rising together leave the wait state on that pulse.
    en = 1'b0;
    cycle(1'b0);
    en = 1'b1;
    repeat (3) run_frame(40);

    // Asynchronous reset between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    for (int j = 0; j < 2; j++) n_frames[j] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    fix_r = 1'b1;
    repeat (15) cycle(1'b0);
    repeat (3) run_frame(100);
    fix_r = 1'b0;

    // Randomized frames with mid-frame mute churn and occasional disables.
    repeat (16) begin
      int len;
      len  = $urandom_range(20, 60);
      mute = 1'($urandom);
      en   = ($urandom_range(0, 7) != 0);
      cycle(1'b1);
      repeat (len / 2) cycle(1'b0);
      mute = 1'($urandom);
      repeat (len - 1 - len / 2) cycle(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_channel_sequencer.md
Name: tmds_channel_sequencer

Overview:
Sits between the display timing generator and the three per-channel DVI TMDS encoders (ch0 blue, ch1 green, ch2 red). It drives each encoder's display enable, control and colour inputs, and holds video off for a configurable number of sync-only frames after reset or enable so the sink can lock. It applies mute (black video with timing preserved) only on frame boundaries. All outputs are registered so encoder inputs change in lock-step.

Parameters:
STARTUP_FRAMES, 2, number of complete sync-only frames sent before video is enabled (0 allowed)
CNT_W, 4, width of the startup frame counter; STARTUP_FRAMES must be < 2**CNT_W

Ports:
i_clk  input  1  pixel clock
i_rst_n  input  1  reset, asynchronous, active-low
i_en  input  1  sequencer enable; low forces return to WAIT_FRAME
i_frame  input  1  one-cycle pulse coincident with the first pixel cycle of a frame
i_hsync  input  1  horizontal sync, passed as-is (polarity untouched)
i_vsync  input  1  vertical sync, passed as-is
i_de  input  1  display enable from timing generator
i_r  input  8  red pixel
i_g  input  8  green pixel
i_b  input  8  blue pixel
i_mute_req  input  1  level request for black video; sampled on i_frame only
o_de  output  1  display enable to all three encoders
o_ctrl_ch0  output  2  {vsync,hsync} to blue encoder
o_ctrl_ch1  output  2  control to green encoder, always 2'b00
o_ctrl_ch2  output  2  control to red encoder, always 2'b00
o_data_ch0  output  8  blue to encoder
o_data_ch1  output  8  green to encoder
o_data_ch2  output  8  red to encoder
o_video_on  output  1  high in ACTIVE or MUTED
o_muted  output  1  high in MUTED

Behaviour:
- Reset: asynchronous on i_rst_n low. State WAIT_FRAME, counter 0, every output 0 (o_de=0, all ctrl 2'b00, all data 8'h00, flags 0).
- Latency: exactly 1 cycle. Outputs at cycle n+1 are computed from inputs at cycle n and the next state (state_d) decided at cycle n. The pixel carrying i_frame therefore already gets the new state's treatment.
- States and output rules:
  - WAIT_FRAME:
    - o_de=0; all ctrl 2'b00; data 0.
    - Discards the partial frame after reset or enable.
    - On i_frame & i_en: counter<=0, go to SYNC_ONLY, or to ACTIVE if STARTUP_FRAMES==0.
  - SYNC_ONLY:
    - o_de=0; o_ctrl_ch0={i_vsync,i_hsync}; data 0.
    - On i_frame: if counter==STARTUP_FRAMES-1, go to ACTIVE (or MUTED if i_mute_req=1); else counter+1.
  - ACTIVE:
    - o_de=i_de; o_ctrl_ch0={i_vsync,i_hsync}.
    - Data = {i_b,i_g,i_r} to ch0/ch1/ch2 when i_de=1, else 0.
    - On i_frame & i_mute_req: go to MUTED.
  - MUTED:
    - As ACTIVE except all data forced 0.
    - On i_frame & !i_mute_req: go to ACTIVE.
- o_ctrl_ch1 and o_ctrl_ch2 are always 2'b00.
- i_mute_req changes between i_frame pulses have no effect. Mute never changes mid-frame.
- i_en low (any state, any cycle) has priority over every other transition: next state WAIT_FRAME, counter 0. Output for that cycle follows WAIT_FRAME rules.
- If i_frame and i_en rise in the same cycle, leave WAIT_FRAME on that pulse.
- i_frame outside a frame start is treated as a frame start; no error detection.
- Counter holds at its value in all states other than SYNC_ONLY. No wrap is reachable given the parameter constraint.
- o_video_on and o_muted are registered from state_d and align with the data they describe.

Decomposition:
- Shared package (display controller): state encoding (WAIT_FRAME, SYNC_ONLY, ACTIVE, MUTED as a 2-bit enum) and CTRL_IDLE=2'b00.
- No sub-module is required. The counter and FSM are inline, and the three TMDS encoders are instantiated by the parent DVI top, not here.

Test Plan:
- Reset then i_en=1, STARTUP_FRAMES=2, three i_frame pulses 100 cycles apart, i_de toggling, i_r=8'hAA -> ctrl_ch0 tracks syncs from the cycle after pulse 1. o_de stays 0 until the cycle after pulse 3, then o_data_ch2=8'hAA during i_de=1 and o_video_on=1.
- STARTUP_FRAMES=0 -> video enabled on the first i_frame after reset; no sync-only frame.
- In ACTIVE, raise i_mute_req mid-frame -> data unchanged until the cycle after the next i_frame, then all data 0 with o_de still following i_de and o_muted=1. Drop the request mid-frame -> black until the next i_frame.
- Drop i_en during ACTIVE -> next cycle o_de=0, ctrl 2'b00, o_video_on=0. Re-raise -> waits for i_frame and repeats the 2-frame startup.
- Assert i_rst_n low mid-line between clock edges -> outputs 0 immediately without a clock edge; after release, behaviour as first scenario.
- Every cycle, check o_ctrl_ch1=o_ctrl_ch2=2'b00 and 1-cycle alignment of ctrl_ch0 to {i_vsync,i_hsync} in non-WAIT states.
